// File: rtl/lc4_icache_dm.sv
// Direct-mapped instruction cache for the LC4 fetch path: combinational hit
// in IDLE, line refill from a fixed-latency memory, saturating hit/miss counters.
module lc4_icache_dm #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 2,
    parameter int MEM_LATENCY = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gwe,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] mem_iaddr,
    input  logic [DATA_W-1:0] mem_idata,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic [1:0]        dbg_state_o
);
    localparam int W     = 1 << OFFSET_BITS;
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;

    if (INDEX_BITS + OFFSET_BITS > ADDR_W - 1) begin : g_geom_check
        $error("lc4_icache_dm: INDEX_BITS+OFFSET_BITS must not exceed ADDR_W-1");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_lat_check
        $error("lc4_icache_dm: MEM_LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_WAIT = 2'd2} state_t;
    state_t state_q, state_d;

    logic [TAG_W-1:0]       a_tag;
    logic [INDEX_BITS-1:0]  a_idx;
    logic [OFFSET_BITS-1:0] a_off;
    assign {a_tag, a_idx, a_off} = addr;

    logic [LINES-1:0]  line_vld_q, line_vld_d;
    logic [TAG_W-1:0]  line_tag_q  [LINES];
    logic [DATA_W-1:0] line_word_q [LINES*W];

    logic [TAG_W-1:0]       fill_tag_q;
    logic [INDEX_BITS-1:0]  fill_idx_q;
    logic [OFFSET_BITS-1:0] iss_q;
    logic [MEM_LATENCY-1:0] pipe_vld_q;
    logic [OFFSET_BITS-1:0] pipe_off_q [MEM_LATENCY];
    logic [15:0]            hit_cnt_q, miss_cnt_q;

    logic                   hit, fill_start, issue, ret_vld, ret_last;
    logic [OFFSET_BITS-1:0] ret_off;

    assign hit        = (state_q == S_IDLE) && line_vld_q[a_idx] && (line_tag_q[a_idx] == a_tag);
    assign fill_start = (state_q == S_IDLE) && !hit && !flush;
    assign issue      = (state_q == S_FILL);
    // The tail of the pipeline marks the word arriving on mem_idata this cycle.
    assign ret_vld    = pipe_vld_q[MEM_LATENCY-1];
    assign ret_off    = pipe_off_q[MEM_LATENCY-1];
    assign ret_last   = ret_vld && (ret_off == OFFSET_BITS'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (gwe) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fill_start) state_d = S_FILL;
            S_FILL:  if (iss_q == OFFSET_BITS'(W - 1)) state_d = S_WAIT;
            S_WAIT:  if (ret_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid     = hit;
        data      = '0;
        mem_iaddr = '0;
        if (hit) data = line_word_q[{a_idx, a_off}];
        if (state_q == S_FILL) mem_iaddr = {fill_tag_q, fill_idx_q, iss_q};
    end

    // Flush is applied last so it wins over a same-edge line install.
    always_comb begin
        line_vld_d = line_vld_q;
        if (fill_start) line_vld_d[a_idx] = 1'b0;
        if (ret_last) line_vld_d[fill_idx_q] = 1'b1;
        if (flush) line_vld_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_vld_q <= '0;
            iss_q      <= '0;
            pipe_vld_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (gwe) begin
            line_vld_q <= line_vld_d;
            if (issue) iss_q <= iss_q + OFFSET_BITS'(1);
            pipe_vld_q[0] <= issue;
            for (int i = 1; i < MEM_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
            if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (fill_start && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && gwe) begin
            if (fill_start) begin
                fill_tag_q <= a_tag;
                fill_idx_q <= a_idx;
            end
            pipe_off_q[0] <= iss_q;
            for (int i = 1; i < MEM_LATENCY; i++) pipe_off_q[i] <= pipe_off_q[i-1];
            if (ret_vld) line_word_q[{fill_idx_q, ret_off}] <= mem_idata;
            if (ret_last) line_tag_q[fill_idx_q] <= fill_tag_q;
        end
    end

    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lc4_icache_dm.sv
// Bench for lc4_icache_dm at default parameters: a timeline model of the cache
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_lc4_icache_dm;
    localparam int L  = 8;
    localparam int WN = 4;

    logic        clk, rst, gwe, flush;
    logic [15:0] addr, data, mem_iaddr, mem_idata, hit_cnt, miss_cnt;
    logic        valid;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    lc4_icache_dm dut (
        .clk(clk), .rst(rst), .gwe(gwe), .flush(flush), .addr(addr),
        .valid(valid), .data(data), .mem_iaddr(mem_iaddr), .mem_idata(mem_idata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    // Memory answers the address seen L enabled cycles earlier; it shares gwe.
    logic [15:0] mhist [L];
    always @(posedge clk) begin
        if (gwe) begin
            mhist[0] <= mem_iaddr;
            for (int i = 1; i < L; i++) mhist[i] <= mhist[i-1];
        end
    end
    assign mem_idata = mem_word(mhist[L-1]);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a miss keeps the cache busy for WN+L cycles, then the line is resident.
    bit          m_live = 1'b0;
    bit          m_vld [32];
    bit [8:0]    m_tag [32];
    bit          m_busy;
    int          m_age;
    bit [4:0]    m_fidx;
    bit [8:0]    m_ftag;
    logic [15:0] m_hits, m_misses, m_iaddr_exp;
    logic [15:0] exp_q [$];

    function automatic bit model_hit(input logic [15:0] a);
        return m_vld[a[6:2]] && (m_tag[a[6:2]] == a[15:7]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
            m_busy = 1'b0; m_age = 0; m_hits = '0; m_misses = '0;
            exp_q.delete(); m_iaddr_exp = '0; m_live = 1'b1;
        end else if (gwe) begin
            if (!m_busy) begin
                if (model_hit(addr)) begin
                    if (m_hits != 16'hFFFF) m_hits++;
                end else if (!flush) begin
                    m_busy = 1'b1; m_age = 1;
                    m_fidx = addr[6:2]; m_ftag = addr[15:7];
                    for (int k = 0; k < WN; k++) exp_q.push_back({addr[15:2], 2'(k)});
                    m_iaddr_exp = exp_q.pop_front();
                    if (m_misses != 16'hFFFF) m_misses++;
                end
            end else if (m_age == WN + L) begin
                m_vld[m_fidx] = 1'b1; m_tag[m_fidx] = m_ftag;
                m_busy = 1'b0; m_iaddr_exp = '0;
            end else begin
                m_age++;
                m_iaddr_exp = (m_age <= WN) ? exp_q.pop_front() : 16'h0;
            end
            if (flush) for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        bit e_hit;
        #2;
        if (m_live) begin
            e_hit = !m_busy && model_hit(addr);
            chk("valid", {15'h0, valid}, {15'h0, e_hit});
            chk("data", data, e_hit ? mem_word(addr) : 16'h0);
            chk("mem_iaddr", mem_iaddr, m_iaddr_exp);
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_misses);
        end
    end

    task automatic cyc(input logic [15:0] a, input logic g, input logic f, input logic r);
        @(negedge clk);
        addr = a; gwe = g; flush = f; rst = r;
        #3;
    endtask

    logic [15:0] iaddr_log [8];

    task automatic fetch(input logic [15:0] a, input int stall_at, input int stall_len,
                         input logic [15:0] stall_hc, output int pen);
        bit done;
        bit st;
        done = 1'b0;
        pen  = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            st = (i >= stall_at) && (i < stall_at + stall_len);
            cyc(a, !st, 1'b0, 1'b0);
            if (i < 8) iaddr_log[i] = mem_iaddr;
            if (st) chk("stall_hit_cnt", hit_cnt, stall_hc);
            if (valid === 1'b1) done = 1'b1;
            else pen++;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL fetch_timeout: addr %04h got no hit, required hit within 60 cycles", a);
        end
    endtask

    initial begin
        int pen;
        rst = 1'b1; gwe = 1'b1; flush = 1'b0; addr = '0;
        cyc(16'h0000, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", {15'h0, valid}, 16'h0);
        chk("rst_data", data, 16'h0);
        chk("rst_iaddr", mem_iaddr, 16'h0);
        chk("rst_hit_cnt", hit_cnt, 16'h0);
        chk("rst_miss_cnt", miss_cnt, 16'h0);

        // Cold miss, then the hit sweep across the line.
        fetch(16'h1234, -1, 0, 16'h0, pen);
        chk("cold_iaddr0", iaddr_log[0], 16'h0000);
        chk("cold_iaddr1", iaddr_log[1], 16'h1234);
        chk("cold_iaddr2", iaddr_log[2], 16'h1235);
        chk("cold_iaddr3", iaddr_log[3], 16'h1236);
        chk("cold_iaddr4", iaddr_log[4], 16'h1237);
        chk("cold_pen", 16'(pen), 16'd13);
        chk("cold_miss_cnt", miss_cnt, 16'd1);
        chk("sweep_d0", data, 16'hD16E);
        cyc(16'h1235, 1'b1, 1'b0, 1'b0);
        chk("sweep_d1", data, 16'hD16F);
        cyc(16'h1236, 1'b1, 1'b0, 1'b0);
        chk("sweep_d2", data, 16'hD16C);
        cyc(16'h1237, 1'b1, 1'b0, 1'b0);
        chk("sweep_d3", data, 16'hD16D);
        chk("sweep_iaddr", mem_iaddr, 16'h0);
        cyc(16'h1234, 1'b0, 1'b0, 1'b0);
        chk("sweep_hit_cnt", hit_cnt, 16'd4);
        chk("frozen_hit_valid", {15'h0, valid}, 16'h1);

        // Conflict eviction on index 0x0D.
        fetch(16'h5234, -1, 0, 16'h0, pen);
        chk("conflict_pen", 16'(pen), 16'd13);
        chk("conflict_data", data, 16'h916E);
        fetch(16'h1234, -1, 0, 16'h0, pen);
        chk("reaccess_pen", 16'(pen), 16'd13);
        chk("reaccess_miss_cnt", miss_cnt, 16'd3);

        // Flush of a resident line, then flush on the last-word edge.
        cyc(16'h1234, 1'b1, 1'b1, 1'b0);
        fetch(16'h1234, -1, 0, 16'h0, pen);
        chk("flush_pen", 16'(pen), 16'd13);
        for (int i = 0; i < 12; i++) cyc(16'h2000, 1'b1, 1'b0, 1'b0);
        cyc(16'h2000, 1'b1, 1'b1, 1'b0);
        fetch(16'h2000, -1, 0, 16'h0, pen);
        chk("flush_last_pen", 16'(pen), 16'd13);
        chk("flush_last_miss_cnt", miss_cnt, 16'd6);

        // Reset in the middle of a fill.
        for (int i = 0; i < 6; i++) cyc(16'h3010, 1'b1, 1'b0, 1'b0);
        cyc(16'h3010, 1'b1, 1'b0, 1'b1);
        cyc(16'h3010, 1'b0, 1'b0, 1'b0);
        chk("midrst_hit_cnt", hit_cnt, 16'd0);
        chk("midrst_miss_cnt", miss_cnt, 16'd0);
        chk("midrst_valid", {15'h0, valid}, 16'h0);
        fetch(16'h3010, -1, 0, 16'h0, pen);
        chk("midrst_pen", 16'(pen), 16'd13);
        chk("midrst_refill_miss_cnt", miss_cnt, 16'd1);

        // Five gwe=0 cycles while waiting on memory.
        fetch(16'h4444, 7, 5, 16'd1, pen);
        chk("stall_pen", 16'(pen), 16'd18);
        chk("stall_data", data, 16'h871E);
        cyc(16'h4444, 1'b0, 1'b0, 1'b0);
        chk("stall_final_hit_cnt", hit_cnt, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish before 100000", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lc4_icache_dm.md
LC4_ICACHE_DM -- requirements
Module: lc4_icache_dm

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width in bits.
REQ-003 SHALL have parameter INDEX_BITS, default 5, log2 of the line count.
REQ-004 SHALL have parameter OFFSET_BITS, default 2, log2 of words per line (W = 2^OFFSET_BITS).
REQ-005 SHALL have parameter MEM_LATENCY, default 8, memory return delay in cycles (legal range 1..15).
REQ-006 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port gwe  in  1  global write enable; 0 freezes all state except under rst.
REQ-009 SHALL have port flush  in  1  invalidate-all request.
REQ-010 SHALL have port addr  in  ADDR_W  fetch address from the processor.
REQ-011 SHALL have port valid  out  1  data holds the hit word this cycle.
REQ-012 SHALL have port data  out  DATA_W  fetched word; 0 when valid=0.
REQ-013 SHALL have port mem_iaddr  out  ADDR_W  memory request address; 0 when idle.
REQ-014 SHALL have port mem_idata  in  DATA_W  word for the mem_iaddr driven MEM_LATENCY cycles earlier.
REQ-015 SHALL have port hit_cnt  out  16  saturating count of hits.
REQ-016 SHALL have port miss_cnt  out  16  saturating count of fills started.

Function
REQ-017 SHALL be direct-mapped: offset = addr[OFFSET_BITS-1:0]; index = next INDEX_BITS; tag = remaining upper bits.
REQ-018 SHALL require INDEX_BITS+OFFSET_BITS <= ADDR_W-1; a violation is an elaboration error.
REQ-019 SHALL, per line, store a valid bit, a tag and W data words.
REQ-020 SHALL use FSM states IDLE, FILL and WAIT.
REQ-021 SHALL, in IDLE, evaluate hit = valid[index] & tag match combinationally; valid=hit; data=word[index][offset] on hit, else 0.
REQ-022 SHALL, on an IDLE miss with gwe=1 and flush=0, latch {tag,index} and go to FILL on the next cycle.
REQ-023 SHALL, in FILL, drive mem_iaddr={tag,index,k} for k=0..W-1 on consecutive cycles, then go to WAIT.
REQ-024 SHALL write each returned word into its data slot on the edge that ends cycle (issue cycle + MEM_LATENCY).
REQ-025 SHALL set the line tag and valid bit with the last returned word, then return to IDLE on the next cycle.
REQ-026 SHALL produce a miss penalty of W+MEM_LATENCY+1 cycles with valid=0 from miss detect to the first hit; defaults give 13.
REQ-027 SHALL hold valid=0 and data=0 in FILL and WAIT regardless of addr; fill completes for the latched line even if addr changes.
REQ-028 SHALL drive mem_iaddr=0 in IDLE and WAIT.
REQ-029 SHALL, when gwe=0, freeze the FSM, issue counter, return pipeline, arrays and counters; outputs reflect the frozen state.
REQ-030 SHALL clear all valid bits at the next edge on flush=1 with gwe=1 in any state.
REQ-031 SHALL, on flush during FILL/WAIT, complete the fill; flush coincident with the last-word install SHALL leave that line invalid (flush wins).
REQ-032 SHALL not start a fill in a cycle where flush=1.
REQ-033 SHALL increment hit_cnt on each IDLE hit cycle with gwe=1, saturating at 16'hFFFF.
REQ-034 SHALL increment miss_cnt once per fill start, saturating at 16'hFFFF.
REQ-035 SHALL, on a conflict miss, overwrite the resident line; there is no other replacement policy.

Reset
REQ-036 SHALL, on rst, go to IDLE, clear all valid bits, clear the issue counter and the return pipeline, and zero hit_cnt and miss_cnt.
REQ-037 SHALL, on rst, drive valid=0, data=0 and mem_iaddr=0 from the next cycle.
REQ-038 SHALL, after rst mid-fill, discard in-flight memory returns and install no partial line.
REQ-039 SHALL not require data/tag arrays to be cleared by rst.

Verification
REQ-040 SHALL cover cold miss at defaults: addr=0x1234 after reset -> mem_iaddr 0x1234,0x1235,0x1236,0x1237 on cycles 1-4; valid=1 at cycle 13; miss_cnt=1.
REQ-041 SHALL cover a hit sweep: after the fill above, addr 0x1234..0x1237 on consecutive cycles -> valid=1 with the words returned by memory, hit_cnt=4, mem_iaddr=0.
REQ-042 SHALL cover conflict eviction: fill 0x1234, then miss 0x5234 (same index) -> refill; a re-access of 0x1234 misses; miss_cnt=3.
REQ-043 SHALL cover flush: flush=1 for one cycle after line 0x1234 is resident -> next access of 0x1234 misses; flush on the last-word edge -> line not valid.
REQ-044 SHALL cover reset mid-fill: rst at fill cycle 6 -> IDLE, counters 0; the first access of the same address misses with a full 13-cycle penalty.
REQ-045 SHALL cover a gwe stall: gwe=0 for 5 cycles during WAIT -> penalty stretches to 18 cycles; hit_cnt unchanged while gwe=0.
